cordic_out_stage: RTL and testbench
===================================

# cordic_out_stage

Output stage of the CORDIC pipeline, placed directly after the last CORDIC_CELL. It captures the final XM/YM pair whenever the last cell asserts its write-enable. It then applies CORDIC gain compensation and undoes the pre-rotation quadrant fold encoded in index_cor[9:8]. Results are queued in a small FIFO and presented on a valid/ready interface to the consumer. The upstream pipeline cannot stall, so the block provides an almost-full warning and a sticky overflow flag.

## Interface
- W, 16, data width of X/Y (two's complement)
- DEPTH, 4, FIFO entries; power of two, ≥2
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- wen_in  in  1  result valid from last CORDIC_CELL
- XM_in  in  W  final X from last cell
- YM_in  in  W  final Y from last cell
- index_cor_in  in  10  direction word; bits [9:8] = quadrant code
- X_out  out  W  compensated X, head of FIFO
- Y_out  out  W  compensated Y, head of FIFO
- valid_out  out  1  FIFO non-empty
- ready_in  in  1  consumer accepts when high with valid_out
- afull  out  1  occupancy ≥ DEPTH-1
- overflow  out  1  sticky: a result was dropped

## Operation
- Stage 1 (registered on wen_in): gain multiply by K ≈ 0.6073.
  - X1 = (X>>>1)+(X>>>3)-(X>>>6)-(X>>>9)-(X>>>13), arithmetic shifts, computed in W+2 bits; same for Y1.
  - Carry the quadrant code and a valid bit v1.
- Stage 2 (registered on v1): quadrant restore, with negation saturating (−(−2^(W−1)) → 2^(W−1)−1).
  - 00: (X1, Y1)
  - 01: (−X1, −Y1)
  - 10: (−Y1, X1)
  - 11: (Y1, −X1)
  - Carry valid bit v2.
- FIFO push = v2. FIFO pop = valid_out && ready_in.
- Occupancy counter 0..DEPTH. Read and write pointers log2(DEPTH) bits wide and wrap naturally.
- Full with push and no pop: the entry is dropped, overflow is set, and occupancy and pointers are unchanged.
- Full with push and pop in the same cycle: both are accepted and occupancy stays at DEPTH.
- Empty with push and pop: pop is ignored because valid_out=0. Occupancy becomes 1.
- overflow clears only on reset.
- Show-ahead output: X_out/Y_out are driven from mem[rd_ptr] and are stable while valid_out && !ready_in.

## Timing
- Reset (async assert, sync release): v1=v2=0, occupancy=0, pointers=0, overflow=0, valid_out=0, afull=0, X_out=Y_out=0.
  - Memory is not cleared; outputs are gated to 0 when empty.
- Latency: wen_in high at edge N → valid_out high after edge N+3 if the FIFO was empty.
- Throughput: one result per clock. Back-to-back wen_in is supported with no bubbles.
- afull and overflow are registered and update on the edge that changes occupancy.
- Reset mid-operation: all in-flight stage data and queued entries are discarded immediately.

## Configuration
- CORDIC_GAIN_COMP_EN defined: stage 1 applies the K multiply.
- CORDIC_GAIN_COMP_EN undefined: stage 1 is a plain register (X1=X, Y1=Y).
  - The pipeline depth is unchanged, so latency stays 3.
  - Saturation on negation still applies.

## Structure
- Package cordic_pkg holds:
  - quadrant code localparams: Q_NONE=2'b00, Q_NEG=2'b01, Q_P90=2'b10, Q_M90=2'b11
  - the gain shift list 1, 3, 6, 9, 13 and the sign of each term
  - the width W
- Sub-module gain_comp: combinational shift-add for one W-bit operand, instantiated twice (X and Y).
  - Under the macro-off build it reduces to a wire.
- The FIFO is kept inline; it is too small to justify a separate module.

## Test plan
- Macro on: X=16384, Y=0, code 00, ready_in=1 → 3 cycles later X_out=9950, Y_out=0, valid_out for 1 cycle.
- Macro on: X=−32768, Y=0, code 01 → X_out=19900, Y_out=0.
- Macro off: X=−32768, Y=5, code 01 → X_out=32767 (saturated), Y_out=−5.
- Code 10: X=1000, Y=200, macro off → X_out=−200, Y_out=1000.
- ready_in=0, 5 back-to-back results, DEPTH=4:
  - afull rises after the 3rd push and the 4 entries are retained in order.
  - The 5th is dropped and overflow=1.
  - Raising ready_in drains the 4 entries in order.
- Full FIFO with simultaneous push and pop: occupancy stays 4 and overflow stays 0. Asserting reset mid-drain clears valid_out and overflow asynchronously.

Source files
------------

// File: rtl/cordic_out_stage_pkg.sv
// Shared constants for the CORDIC output stage: data width, FIFO depth,
// quadrant codes and the shift/sign list that approximates the CORDIC gain K.
package cordic_pkg;

  localparam int W     = 16;
  localparam int DEPTH = 4;

  localparam logic [1:0] Q_NONE = 2'b00;
  localparam logic [1:0] Q_NEG  = 2'b01;
  localparam logic [1:0] Q_P90  = 2'b10;
  localparam logic [1:0] Q_M90  = 2'b11;

  // K ~= 2^-1 + 2^-3 - 2^-6 - 2^-9 - 2^-13
  localparam int GAIN_TERMS = 5;
  localparam int GAIN_SHIFT [GAIN_TERMS] = '{1, 3, 6, 9, 13};
  localparam bit GAIN_NEG   [GAIN_TERMS] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

endpackage

// File: rtl/cordic_out_stage_if.sv
// Result path of the CORDIC output stage: upstream capture inputs plus the
// valid/ready consumer side and status flags.
interface cordic_out_stage_if #(parameter int W = cordic_pkg::W);

  logic                wen_in;
  logic signed [W-1:0] XM_in;
  logic signed [W-1:0] YM_in;
  logic [9:0]          index_cor_in;
  logic signed [W-1:0] X_out;
  logic signed [W-1:0] Y_out;
  logic                valid_out;
  logic                ready_in;
  logic                afull;
  logic                overflow;

  modport master (
    output wen_in, XM_in, YM_in, index_cor_in, ready_in,
    input  X_out, Y_out, valid_out, afull, overflow
  );

  modport slave (
    input  wen_in, XM_in, YM_in, index_cor_in, ready_in,
    output X_out, Y_out, valid_out, afull, overflow
  );

endinterface

// File: rtl/cordic_out_stage_gain_comp.sv
// Combinational CORDIC gain compensation for one operand (shift-add by K).
// With CORDIC_GAIN_COMP_EN undefined the operand is only sign-extended.
module gain_comp
  import cordic_pkg::*;
#(
  parameter int W = cordic_pkg::W
) (
  input  logic signed [W-1:0] d_i,
  output logic signed [W+1:0] q_o
);

  logic signed [W+1:0] ext;
  assign ext = {{2{d_i[W-1]}}, d_i};

`ifdef CORDIC_GAIN_COMP_EN
  // Two guard bits keep the partial sums from wrapping before the final term.
  logic signed [W+1:0] acc [GAIN_TERMS+1];
  assign acc[0] = '0;

  for (genvar gi = 0; gi < GAIN_TERMS; gi++) begin : g_term
    if (GAIN_NEG[gi]) begin : g_sub
      assign acc[gi+1] = acc[gi] - (ext >>> GAIN_SHIFT[gi]);
    end else begin : g_add
      assign acc[gi+1] = acc[gi] + (ext >>> GAIN_SHIFT[gi]);
    end
  end

  assign q_o = acc[GAIN_TERMS];
`else
  assign q_o = ext;
`endif

endmodule

// File: rtl/cordic_out_stage.sv
// CORDIC output stage: gain compensation, quadrant restore and a show-ahead
// result FIFO with almost-full/overflow flags. Gain multiply via CORDIC_GAIN_COMP_EN.
module cordic_out_stage
  import cordic_pkg::*;
#(
  parameter int W     = cordic_pkg::W,
  parameter int DEPTH = cordic_pkg::DEPTH
) (
  input  logic               clk,
  input  logic               reset,
  cordic_out_stage_if.slave  bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int XW = W + 2;
  typedef logic signed [XW-1:0] ext_t;

  localparam ext_t           SAT_MAX   = ext_t'((2 ** (W - 1)) - 1);
  localparam ext_t           SAT_MIN   = -SAT_MAX - ext_t'(1);
  localparam logic [PW:0]    CNT_FULL  = DEPTH[PW:0];
  localparam logic [PW:0]    CNT_AFULL = CNT_FULL - 1'b1;

  function automatic logic signed [W-1:0] sat(input ext_t v);
    if (v > SAT_MAX) return SAT_MAX[W-1:0];
    if (v < SAT_MIN) return SAT_MIN[W-1:0];
    return v[W-1:0];
  endfunction

  // Stage 1: gain compensation, captured on wen_in
  ext_t       xg, yg;
  ext_t       x1_q, y1_q;
  logic [1:0] quad1_q;
  logic       v1_q;

  gain_comp #(.W(W)) u_gain_x (.d_i(bus.XM_in), .q_o(xg));
  gain_comp #(.W(W)) u_gain_y (.d_i(bus.YM_in), .q_o(yg));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v1_q    <= 1'b0;
      x1_q    <= '0;
      y1_q    <= '0;
      quad1_q <= Q_NONE;
    end else begin
      v1_q <= bus.wen_in;
      if (bus.wen_in) begin
        x1_q    <= xg;
        y1_q    <= yg;
        quad1_q <= bus.index_cor_in[9:8];
      end
    end
  end

  // Low direction bits are consumed upstream; only the quadrant code matters here.
  logic unused_dir;
  assign unused_dir = ^bus.index_cor_in[7:0];

  // Stage 2: undo the quadrant fold with saturating negation
  logic signed [W-1:0] x2_d, y2_d, x2_q, y2_q;
  logic                v2_q;

  always_comb begin
    x2_d = sat(x1_q);
    y2_d = sat(y1_q);
    case (quad1_q)
      Q_NEG: begin
        x2_d = sat(-x1_q);
        y2_d = sat(-y1_q);
      end
      Q_P90: begin
        x2_d = sat(-y1_q);
        y2_d = sat(x1_q);
      end
      Q_M90: begin
        x2_d = sat(y1_q);
        y2_d = sat(-x1_q);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v2_q <= 1'b0;
      x2_q <= '0;
      y2_q <= '0;
    end else begin
      v2_q <= v1_q;
      if (v1_q) begin
        x2_q <= x2_d;
        y2_q <= y2_d;
      end
    end
  end

  // Result FIFO
  logic [W-1:0]  mem_x [DEPTH];
  logic [W-1:0]  mem_y [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW:0]   count_q, count_d;
  logic          afull_q, overflow_q;
  logic          valid, full, pop, wr_en, drop;

  assign valid = (count_q != '0);
  assign full  = (count_q == CNT_FULL);
  assign pop   = valid && bus.ready_in;
  // A pop frees the slot a same-cycle push needs, even when full.
  assign wr_en = v2_q && (!full || pop);
  assign drop  = v2_q && full && !pop;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)   rd_ptr_d = rd_ptr_q + 1'b1;
    if (wr_en && !pop)      count_d = count_q + 1'b1;
    else if (!wr_en && pop) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      afull_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      afull_q    <= (count_d >= CNT_AFULL);
      overflow_q <= overflow_q | drop;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_x[wr_ptr_q] <= x2_q;
      mem_y[wr_ptr_q] <= y2_q;
    end
  end

  assign bus.valid_out = valid;
  assign bus.X_out     = valid ? mem_x[rd_ptr_q] : '0;
  assign bus.Y_out     = valid ? mem_y[rd_ptr_q] : '0;
  assign bus.afull     = afull_q;
  assign bus.overflow  = overflow_q;

endmodule

// File: tb/tb_cordic_out_stage.sv
// Directed bench for cordic_out_stage; expected values follow CORDIC_GAIN_COMP_EN.
module tb_cordic_out_stage;

`ifdef CORDIC_GAIN_COMP_EN
  localparam bit GAIN_ON = 1'b1;
`else
  localparam bit GAIN_ON = 1'b0;
`endif

  localparam int XIN    [5] = '{1024, 2048, 4096, 8192, 16384};
  localparam int EXP_ON [5] = '{622, 1244, 2488, 4975, 9950};

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  cordic_out_stage_if #(.W(16)) bus ();

  cordic_out_stage #(.W(16), .DEPTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  function automatic int exp_b(input int k);
    return GAIN_ON ? EXP_ON[k] : XIN[k];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic w, input int x, input int y, input logic [1:0] q);
    bus.wen_in       = w;
    bus.XM_in        = 16'(x);
    bus.YM_in        = 16'(y);
    bus.index_cor_in = {q, 8'h5A};
  endtask

  task automatic test_reset();
    reset        = 1'b0;
    bus.ready_in = 1'b0;
    drive(1'b0, 0, 0, 2'b00);
    tick();
    tick();
    checks++;
    if (bus.valid_out !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b expected 0", bus.valid_out); end
    checks++;
    if (bus.afull !== 1'b0) begin errors++; $display("FAIL rst_afull: got %b expected 0", bus.afull); end
    checks++;
    if (bus.overflow !== 1'b0) begin errors++; $display("FAIL rst_ovf: got %b expected 0", bus.overflow); end
    checks++;
    if (bus.X_out !== 16'sd0) begin errors++; $display("FAIL rst_x: got %0d expected 0", bus.X_out); end
    checks++;
    if (bus.Y_out !== 16'sd0) begin errors++; $display("FAIL rst_y: got %0d expected 0", bus.Y_out); end
    @(negedge clk);
    reset = 1'b1;
    tick();
  endtask

  task automatic test_single(input string name, input int x, input int y, input logic [1:0] q,
                             input int ex, input int ey);
    logic signed [15:0] ex16, ey16;
    ex16 = 16'(ex);
    ey16 = 16'(ey);
    bus.ready_in = 1'b1;
    drive(1'b1, x, y, q);
    tick();
    drive(1'b0, 0, 0, 2'b00);
    checks++;
    if (bus.valid_out !== 1'b0) begin errors++; $display("FAIL %s_lat1: valid got %b expected 0", name, bus.valid_out); end
    tick();
    checks++;
    if (bus.valid_out !== 1'b0) begin errors++; $display("FAIL %s_lat2: valid got %b expected 0", name, bus.valid_out); end
    tick();
    checks++;
    if (bus.valid_out !== 1'b1) begin errors++; $display("FAIL %s_lat3: valid got %b expected 1", name, bus.valid_out); end
    checks++;
    if (bus.X_out !== ex16) begin errors++; $display("FAIL %s_x: got %0d expected %0d", name, bus.X_out, ex16); end
    checks++;
    if (bus.Y_out !== ey16) begin errors++; $display("FAIL %s_y: got %0d expected %0d", name, bus.Y_out, ey16); end
    $display("txn %s: X_in=%0d Y_in=%0d q=%b -> X_out=%0d Y_out=%0d", name, x, y, q, bus.X_out, bus.Y_out);
    tick();
    checks++;
    if (bus.valid_out !== 1'b0 || bus.X_out !== 16'sd0) begin
      errors++;
      $display("FAIL %s_pop: valid=%b X_out=%0d expected valid=0 X_out=0", name, bus.valid_out, bus.X_out);
    end
  endtask

  task automatic test_back_to_back();
    logic signed [15:0] e;
    bus.ready_in = 1'b0;
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, XIN[k], 0, 2'b00);
      tick();
      if (k == 3) begin
        checks++;
        if (bus.afull !== 1'b0) begin errors++; $display("FAIL b2b_afull_2: got %b expected 0", bus.afull); end
      end
      if (k == 4) begin
        checks++;
        if (bus.afull !== 1'b1) begin errors++; $display("FAIL b2b_afull_3: got %b expected 1", bus.afull); end
      end
    end
    drive(1'b0, 0, 0, 2'b00);
    tick();
    checks++;
    if (bus.overflow !== 1'b0) begin errors++; $display("FAIL b2b_ovf_pre: got %b expected 0", bus.overflow); end
    tick();
    checks++;
    if (bus.overflow !== 1'b1) begin errors++; $display("FAIL b2b_ovf_drop: got %b expected 1", bus.overflow); end
    tick();
    e = 16'(exp_b(0));
    checks++;
    if (bus.valid_out !== 1'b1 || bus.X_out !== e) begin
      errors++;
      $display("FAIL b2b_hold: valid=%b X_out=%0d expected valid=1 X_out=%0d", bus.valid_out, bus.X_out, e);
    end
    bus.ready_in = 1'b1;
    for (int k = 0; k < 4; k++) begin
      e = 16'(exp_b(k));
      checks++;
      if (bus.valid_out !== 1'b1 || bus.X_out !== e) begin
        errors++;
        $display("FAIL b2b_drain%0d: valid=%b X_out=%0d expected valid=1 X_out=%0d", k, bus.valid_out, bus.X_out, e);
      end
      $display("txn drain%0d: X_out=%0d Y_out=%0d", k, bus.X_out, bus.Y_out);
      tick();
    end
    checks++;
    if (bus.valid_out !== 1'b0 || bus.afull !== 1'b0) begin
      errors++;
      $display("FAIL b2b_empty: valid=%b afull=%b expected 0 0", bus.valid_out, bus.afull);
    end
    checks++;
    if (bus.overflow !== 1'b1) begin errors++; $display("FAIL b2b_ovf_sticky: got %b expected 1", bus.overflow); end
  endtask

  task automatic test_full_push_pop();
    logic signed [15:0] e;
    #3;
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    tick();
    checks++;
    if (bus.overflow !== 1'b0) begin errors++; $display("FAIL pp_ovf_rst: got %b expected 0", bus.overflow); end
    bus.ready_in = 1'b0;
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, XIN[k], 0, 2'b00);
      tick();
    end
    drive(1'b0, 0, 0, 2'b00);
    tick();
    e = 16'(exp_b(0));
    checks++;
    if (bus.afull !== 1'b1 || bus.X_out !== e) begin
      errors++;
      $display("FAIL pp_full: afull=%b X_out=%0d expected afull=1 X_out=%0d", bus.afull, bus.X_out, e);
    end
    bus.ready_in = 1'b1;
    tick();
    e = 16'(exp_b(1));
    checks++;
    if (bus.overflow !== 1'b0) begin errors++; $display("FAIL pp_ovf: got %b expected 0", bus.overflow); end
    checks++;
    if (bus.afull !== 1'b1 || bus.X_out !== e) begin
      errors++;
      $display("FAIL pp_head: afull=%b X_out=%0d expected afull=1 X_out=%0d", bus.afull, bus.X_out, e);
    end
    $display("txn push+pop: X_out=%0d afull=%b overflow=%b", bus.X_out, bus.afull, bus.overflow);
    // An extra push into a still-full FIFO must be dropped.
    bus.ready_in = 1'b0;
    drive(1'b1, -32768, 0, 2'b00);
    tick();
    drive(1'b0, 0, 0, 2'b00);
    tick();
    tick();
    checks++;
    if (bus.overflow !== 1'b1 || bus.X_out !== e) begin
      errors++;
      $display("FAIL pp_still_full: overflow=%b X_out=%0d expected overflow=1 X_out=%0d", bus.overflow, bus.X_out, e);
    end
    bus.ready_in = 1'b1;
    tick();
    e = 16'(exp_b(2));
    checks++;
    if (bus.X_out !== e) begin errors++; $display("FAIL pp_drain: got %0d expected %0d", bus.X_out, e); end
    #3;
    reset = 1'b0;
    #1;
    checks++;
    if (bus.valid_out !== 1'b0 || bus.overflow !== 1'b0 || bus.afull !== 1'b0 || bus.X_out !== 16'sd0) begin
      errors++;
      $display("FAIL pp_async_rst: valid=%b ovf=%b afull=%b X_out=%0d expected all 0",
               bus.valid_out, bus.overflow, bus.afull, bus.X_out);
    end
    @(negedge clk);
    reset = 1'b1;
    tick();
    tick();
    checks++;
    if (bus.valid_out !== 1'b0) begin errors++; $display("FAIL pp_discard: valid got %b expected 0", bus.valid_out); end
  endtask

  initial begin
    test_reset();
    test_single("q00", 16384, 0, 2'b00, GAIN_ON ? 9950 : 16384, 0);
    test_single("q01_min", -32768, 0, 2'b01, GAIN_ON ? 19900 : 32767, 0);
    test_single("q01_sat", -32768, 5, 2'b01, GAIN_ON ? 19900 : 32767, GAIN_ON ? -2 : -5);
    test_single("q10", 1000, 200, 2'b10, GAIN_ON ? -122 : -200, GAIN_ON ? 609 : 1000);
    test_single("q11_min", -32768, -32768, 2'b11, GAIN_ON ? -19900 : -32768, GAIN_ON ? 19900 : 32767);
    test_back_to_back();
    test_full_push_pop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
